// File: rtl/mux4_arbiter_pkg.sv
// Shared types and constants for the 4:1 select arbiter.
// Imported by the picker and the top-level FSM.
package mux4_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mux4_arbiter_rr_pick4.sv
// Round-robin picker: first set request at or after ptr.
// Purely combinational; the FSM owns the pointer.
module rr_pick4
    import mux4_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W-1:0] j;

    // scan ptr, ptr+1, ... with natural 2-bit wrap
    always_comb begin
        idx   = ptr;
        found = 1'b0;
        j     = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            j = ptr + SEL_W'(k);
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/mux4_arbiter.sv
// Burst-limited round-robin arbiter driving the select of an
// external 4:1 16-bit mux; grant/sel/out_valid are registered.
module mux4_arbiter #(
    parameter int BURST = 4,
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] ack,
    output logic             busy
);

    import mux4_arbiter_pkg::*;

    state_t             state, state_n;
    logic [SEL_W-1:0]   ptr, ptr_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [SEL_W-1:0]   sel_n;
    logic [N_REQ-1:0]   grant_n;
    logic               valid_n;

    logic [SEL_W-1:0]   pick_ptr;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_found;
    logic               accept;
    logic               more;

    assign accept = out_valid & out_ready;
    assign ack    = {N_REQ{accept}} & grant;
    assign busy   = (state == BUSY);

    // after a finished grant the search resumes just past the winner
    assign pick_ptr = (state == BUSY) ? sel + SEL_W'(1) : ptr;

    // the owner keeps the bus while it has more and budget remains
    assign more = accept & req[sel] & (cnt < CNT_W'(BURST - 1));

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // next-state: arbitrate from IDLE, hold or hand over in BUSY
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        sel_n   = sel;
        grant_n = grant;
        valid_n = out_valid;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n = BUSY;
                    sel_n   = pick_idx;
                    grant_n = N_REQ'(1) << pick_idx;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                if (more) begin
                    cnt_n = cnt + CNT_W'(1);
                end else if (accept) begin
                    ptr_n = sel + SEL_W'(1);
                    cnt_n = '0;
                    if (pick_found) begin
                        sel_n   = pick_idx;
                        grant_n = N_REQ'(1) << pick_idx;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        valid_n = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state and registered outputs; reset drops any in-flight word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            sel       <= '0;
            grant     <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            sel       <= sel_n;
            grant     <= grant_n;
            out_valid <= valid_n;
        end
    end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Scenario bench for mux4_arbiter with BURST=4 and BURST=1 copies.
// Expected grants/selects are queued as stimulus is applied.
module tb_mux4_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       out_ready = 1'b0;

    logic [1:0] sel_a, sel_b;
    logic       ov_a, ov_b;
    logic [3:0] grant_a, grant_b;
    logic [3:0] ack_a, ack_b;
    logic       busy_a, busy_b;

    int errors = 0;
    int checks = 0;

    logic [3:0] expq[$];
    logic [3:0] exp_v;

    always #5 clk = ~clk;

    mux4_arbiter #(.BURST(4), .N_REQ(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel_a),
        .out_valid (ov_a),
        .grant     (grant_a),
        .ack       (ack_a),
        .busy      (busy_a)
    );

    mux4_arbiter #(.BURST(1), .N_REQ(4)) u_b1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel_b),
        .out_valid (ov_b),
        .grant     (grant_b),
        .ack       (ack_b),
        .busy      (busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req       = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (ov_a !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid cyc%0d: got %b want 0", c, ov_a);
            end
            checks++;
            if (grant_a !== 4'b0000) begin
                errors++;
                $display("FAIL idle_grant cyc%0d: got %b want 0000", c, grant_a);
            end
            checks++;
            if (sel_a !== 2'b00) begin
                errors++;
                $display("FAIL idle_sel cyc%0d: got %b want 00", c, sel_a);
            end
            checks++;
            if (ack_a !== 4'b0000 || busy_a !== 1'b0) begin
                errors++;
                $display("FAIL idle_ack_busy cyc%0d: got %b/%b want 0000/0",
                         c, ack_a, busy_a);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        tick();
        req       = 4'b0100;
        out_ready = 1'b1;
        expq.push_back(4'b0100);
        tick();
        req = 4'b0000;
        #1;
        checks++;
        if (ov_a !== 1'b1 || sel_a !== 2'b10) begin
            errors++;
            $display("FAIL single_valid_sel: got %b/%b want 1/10", ov_a, sel_a);
        end
        exp_v = expq.pop_front();
        checks++;
        if (grant_a !== exp_v || ack_a !== exp_v) begin
            errors++;
            $display("FAIL single_grant_ack: got %b/%b want %b", grant_a, ack_a, exp_v);
        end
        tick();
        checks++;
        if (ov_a !== 1'b0 || grant_a !== 4'b0000 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL single_to_idle: got v%b g%b b%b want v0 g0000 b0",
                     ov_a, grant_a, busy_a);
        end
        checks++;
        if (sel_a !== 2'b10) begin
            errors++;
            $display("FAIL single_sel_hold: got %b want 10", sel_a);
        end
    endtask

    task automatic test_burst1();
        do_reset();
        req       = 4'b1111;
        out_ready = 1'b1;
        expq.push_back(4'b0001);
        expq.push_back(4'b0010);
        expq.push_back(4'b0100);
        expq.push_back(4'b1000);
        expq.push_back(4'b0001);
        for (int c = 0; c < 5; c++) begin
            tick();
            exp_v = expq.pop_front();
            checks++;
            if (ov_b !== 1'b1 || grant_b !== exp_v) begin
                errors++;
                $display("FAIL b1_grant beat%0d: got v%b g%b want v1 g%b",
                         c, ov_b, grant_b, exp_v);
            end
            checks++;
            if (ack_b !== exp_v) begin
                errors++;
                $display("FAIL b1_ack beat%0d: got %b want %b", c, ack_b, exp_v);
            end
        end
    endtask

    task automatic test_burst4();
        do_reset();
        req       = 4'b0011;
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) expq.push_back(4'd0);
        for (int b = 0; b < 4; b++) expq.push_back(4'd1);
        expq.push_back(4'd0);
        for (int c = 0; c < 9; c++) begin
            tick();
            exp_v = expq.pop_front();
            checks++;
            if (ov_a !== 1'b1 || sel_a !== exp_v[1:0]) begin
                errors++;
                $display("FAIL b4_sel beat%0d: got v%b s%b want v1 s%b",
                         c, ov_a, sel_a, exp_v[1:0]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        req       = 4'b0010;
        out_ready = 1'b0;
        tick();
        req = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (sel_a !== 2'b01 || grant_a !== 4'b0010 || ack_a !== 4'b0000) begin
                errors++;
                $display("FAIL stall_hold cyc%0d: got s%b g%b a%b want s01 g0010 a0000",
                         c, sel_a, grant_a, ack_a);
            end
            tick();
        end
        out_ready = 1'b1;
        req       = 4'b0100;
        expq.push_back(4'b0100);
        #1;
        checks++;
        if (ack_a !== 4'b0010) begin
            errors++;
            $display("FAIL stall_ack: got %b want 0010", ack_a);
        end
        tick();
        exp_v = expq.pop_front();
        checks++;
        if (grant_a !== exp_v || ov_a !== 1'b1) begin
            errors++;
            $display("FAIL stall_next: got g%b v%b want g%b v1", grant_a, ov_a, exp_v);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req       = 4'b0010;
        out_ready = 1'b1;
        tick();
        req = 4'b0100;
        tick();
        out_ready = 1'b0;
        tick();
        checks++;
        if (grant_a !== 4'b0100 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got g%b b%b want g0100 b1", grant_a, busy_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov_a !== 1'b0 || grant_a !== 4'b0000 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v%b g%b b%b want 0/0000/0",
                     ov_a, grant_a, busy_a);
        end
        checks++;
        if (sel_a !== 2'b00 || ack_a !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset_sel_ack: got s%b a%b want 00/0000", sel_a, ack_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1010;
        expq.push_back(4'b0010);
        tick();
        exp_v = expq.pop_front();
        checks++;
        if (grant_a !== exp_v) begin
            errors++;
            $display("FAIL ptr_restart: got %b want %b", grant_a, exp_v);
        end
        do_reset();
        req       = 4'b1000;
        out_ready = 1'b1;
        expq.push_back(4'b1000);
        tick();
        exp_v = expq.pop_front();
        checks++;
        if (grant_a !== exp_v || sel_a !== 2'b11) begin
            errors++;
            $display("FAIL post_reset_grant: got g%b s%b want g%b s11",
                     grant_a, sel_a, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst1();
        test_burst4();
        test_stall();
        test_mid_reset();
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
